// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer: JTAG master that runs TAP reset, IR scan and DR scan commands and captures TDO.
module jtag_scan_sequencer #(
   parameter int MAX_LEN = 80,
   parameter int LEN_W   = 7
) (
   input  logic               CK,
   input  logic               RST,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               TCK_O,
   output logic               TMS_O,
   output logic               TDI_O,
   input  logic               TDO_I
);
   typedef enum logic [2:0] {IDLE, RESETSEQ, PRE, SHIFT, POST, RESP} state_t;
   state_t state, state_n;
   logic phase, phase_n, synced, synced_n, err, err_n;
   logic tck, tck_n, tms, tms_n, tdi, tdi_n;
   logic [1:0] op_q, op_n;
   logic [LEN_W-1:0] cnt, cnt_n, len_q, len_n, last_cnt;
   logic [MAX_LEN-1:0] data_q, data_n, cap, cap_n;
   logic shifting, last, illegal;
   assign shifting = state inside {RESETSEQ, PRE, SHIFT, POST};
   assign last_cnt = state == RESETSEQ ? LEN_W'(5) :
                     state == PRE ? (op_q == 2'd1 ? LEN_W'(3) : LEN_W'(2)) :
                     state == SHIFT ? len_q - LEN_W'(1) : LEN_W'(1);
   assign last = cnt == last_cnt;
   assign illegal = cmd_op == 2'd3 ||
                    (cmd_op != 2'd2 && (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)));
   assign cmd_ready = state == IDLE;
   assign rsp_valid = state == RESP;
   assign rsp_data = cap;
   assign rsp_err = err;
   assign busy = shifting;
   assign TCK_O = tck;
   assign TMS_O = tms;
   assign TDI_O = tdi;
   // next state: accept, step the two-phase TCK through each segment, and hold the response until consumed
   always_comb begin
      state_n = state;
      phase_n = phase;
      cnt_n = cnt;
      synced_n = synced;
      op_n = op_q;
      len_n = len_q;
      data_n = data_q;
      cap_n = cap;
      err_n = err;
      tck_n = 1'b0;
      if (state == IDLE && cmd_valid) begin
         op_n = cmd_op;
         len_n = cmd_len;
         data_n = cmd_data;
         cap_n = '0;
         err_n = illegal;
         cnt_n = '0;
         phase_n = 1'b0;
         state_n = illegal ? RESP : (cmd_op == 2'd2 || !synced) ? RESETSEQ : PRE;
      end else if (shifting) begin
         phase_n = ~phase;
         tck_n = ~phase;
         if (phase) begin
            cnt_n = last ? '0 : cnt + LEN_W'(1);
            if (state == SHIFT) cap_n[cnt] = TDO_I;
            if (last) state_n = state == RESETSEQ ? (op_q == 2'd2 ? RESP : PRE) :
                                state == PRE ? SHIFT : state == SHIFT ? POST : RESP;
            if (last && state == RESETSEQ) synced_n = 1'b1;
         end
      end else if (state == RESP && rsp_ready) begin
         state_n = IDLE;
         cap_n = '0;
         err_n = 1'b0;
      end
      tms_n = state_n == RESETSEQ ? cnt_n != LEN_W'(5) :
              state_n == PRE ? (op_q == 2'd1 ? cnt_n < LEN_W'(2) : cnt_n == '0) :
              state_n == SHIFT ? cnt_n == len_q - LEN_W'(1) :
              state_n == POST ? cnt_n == '0 : ~synced_n;
      tdi_n = state_n == SHIFT && data_q[cnt_n];
   end
   // state and registered pins; reset drops TCK at once and discards any pending response
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         phase <= 1'b0;
         cnt <= '0;
         synced <= 1'b0;
         op_q <= '0;
         len_q <= '0;
         data_q <= '0;
         cap <= '0;
         err <= 1'b0;
         tck <= 1'b0;
         tms <= 1'b1;
         tdi <= 1'b0;
      end else begin
         state <= state_n;
         phase <= phase_n;
         cnt <= cnt_n;
         synced <= synced_n;
         op_q <= op_n;
         len_q <= len_n;
         data_q <= data_n;
         cap <= cap_n;
         err <= err_n;
         tck <= tck_n;
         tms <= tms_n;
         tdi <= tdi_n;
      end
   end
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer: table-driven scoreboard bench for jtag_scan_sequencer with a TDO loopback model.
module tb_jtag_scan_sequencer;
   localparam int ML = 80;
   localparam int LW = 7;
   logic CK = 1'b0, RST = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0, TDO_I = 1'b0;
   logic [1:0] cmd_op = '0;
   logic [LW-1:0] cmd_len = '0;
   logic [ML-1:0] cmd_data = '0;
   logic cmd_ready, rsp_valid, rsp_err, busy, TCK_O, TMS_O, TDI_O;
   logic [ML-1:0] rsp_data;
   int tests = 0, fails = 0;
   typedef struct {logic [ML-1:0] data; logic err; int lat; int ntck; logic [127:0] tms;} exp_t;
   typedef struct {logic [1:0] op; logic [LW-1:0] len; logic [ML-1:0] data; logic inv; int lat;} vec_t;
   exp_t sb[$];
   vec_t vecs[10];
   bit synced_m = 1'b0;
   logic inv = 1'b0, prev = 1'b0;
   int mon_n = 0;
   logic [127:0] tms_got = '0;

   jtag_scan_sequencer #(.MAX_LEN(ML), .LEN_W(LW)) dut (
      .CK(CK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .TCK_O(TCK_O), .TMS_O(TMS_O),
      .TDI_O(TDI_O), .TDO_I(TDO_I));

   always #5 CK = ~CK;

   // wrapper model: TDO returns the TDI of the previous TCK (optionally inverted); logs TMS per pulse
   always @(posedge TCK_O) begin
      if (mon_n < 128) tms_got[mon_n] = TMS_O;
      mon_n++;
      TDO_I = prev ^ inv;
      prev = TDI_O;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [ML-1:0] data,
                        input logic inv_i, input int lat);
      exp_t e;
      int n;
      bit ill;
      ill = op == 2'd3 || (op != 2'd2 && (len == 0 || int'(len) > ML));
      e.data = '0;
      e.err = ill;
      e.tms = '0;
      e.lat = lat;
      n = 0;
      if (!ill) begin
         if (op == 2'd2 || !synced_m)
            for (int i = 0; i < 6; i++) begin e.tms[n] = i < 5; n++; end
         if (op != 2'd2) begin
            for (int i = 0; i < (op == 2'd1 ? 4 : 3); i++) begin
               e.tms[n] = op == 2'd1 ? i < 2 : i == 0;
               n++;
            end
            for (int k = 0; k < int'(len); k++) begin
               e.tms[n] = k == int'(len) - 1;
               n++;
               e.data[k] = (k == 0) ? inv_i : data[k-1] ^ inv_i;
            end
            e.tms[n] = 1'b1;
            e.tms[n+1] = 1'b0;
            n += 2;
         end
         synced_m = 1'b1;
      end
      e.ntck = n;
      sb.push_back(e);
      @(negedge CK);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_len = len;
      cmd_data = data;
      inv = inv_i;
      mon_n = 0;
      @(posedge CK);
      #1;
      cmd_valid = 1'b0;
      cmd_data = ~data;
      cmd_len = ~len;
   endtask

   task automatic wait_rsp(input string name, input int hold, input bit collide);
      exp_t e;
      int n;
      logic [127:0] m;
      e = sb.pop_front();
      n = 0;
      do begin @(negedge CK); n++; end while (!rsp_valid && n < 400);
      check({name, " latency"}, n, e.lat);
      check({name, " err"}, rsp_err, e.err);
      check({name, " data"}, rsp_data, e.data);
      check({name, " tck count"}, mon_n, e.ntck);
      m = ~({128{1'b1}} << e.ntck);
      check({name, " tms seq"}, tms_got & m, e.tms);
      check({name, " busy/tck at rsp"}, {busy, TCK_O}, 2'b00);
      for (int i = 0; i < hold; i++) begin
         @(negedge CK);
         check({name, " hold"}, {rsp_valid, cmd_ready, rsp_err, rsp_data == e.data}, {1'b1, 1'b0, e.err, 1'b1});
      end
      rsp_ready = 1'b1;
      if (collide) begin
         cmd_valid = 1'b1;
         cmd_op = 2'd0;
         cmd_len = LW'(1);
      end
      @(posedge CK);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      @(negedge CK);
      check({name, " after consume"}, {cmd_ready, rsp_valid, rsp_data == '0, rsp_err, busy}, 5'b10100);
      check({name, " idle tms"}, TMS_O, !synced_m);
   endtask

   initial begin
      vecs[0] = '{2'd1, LW'(2),  ML'(2'b10), 1'b0, 17};
      vecs[1] = '{2'd0, LW'(75), {20{4'h5}}, 1'b0, 161};
      vecs[2] = '{2'd0, LW'(0),  ML'(5),     1'b0, 1};
      vecs[3] = '{2'd1, LW'(81), ML'(7),     1'b0, 1};
      vecs[4] = '{2'd3, LW'(5),  ML'(9),     1'b0, 1};
      vecs[5] = '{2'd0, LW'(1),  ML'(1),     1'b1, 13};
      vecs[6] = '{2'd1, LW'(80), ML'({$urandom(), $urandom(), $urandom()}), 1'b0, 173};
      vecs[7] = '{2'd2, LW'(0),  ML'(3),     1'b0, 13};
      vecs[8] = '{2'd0, LW'(80), ML'({$urandom(), $urandom(), $urandom()}), 1'b1, 171};
      vecs[9] = '{2'd1, LW'(7),  ML'(7'b1011001), 1'b0, 27};
      repeat (3) @(negedge CK);
      check("reset pins", {cmd_ready, rsp_valid, rsp_err, busy, TCK_O, TMS_O, TDI_O}, 7'b1000010);
      check("reset data", rsp_data, '0);
      RST = 1'b0;
      issue(2'd2, '0, '0, 1'b0, 13);
      wait_rsp("reset op", 0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].inv, vecs[i].lat);
         wait_rsp($sformatf("vec%0d", i), 0, 1'b0);
      end
      issue(2'd0, '0, '1, 1'b0, 1);
      wait_rsp("illegal hold", 10, 1'b1);
      issue(2'd1, LW'(81), '1, 1'b0, 1);
      wait_rsp("illegal hold 81", 10, 1'b0);
      issue(2'd0, LW'(80), ML'({$urandom(), $urandom(), $urandom()}), 1'b0, 171);
      repeat (46) @(negedge CK);
      for (int i = 0; i < 4 && !TCK_O; i++) @(negedge CK);
      check("tck high before abort", TCK_O, 1'b1);
      RST = 1'b1;
      #1;
      check("async abort", {TCK_O, busy, cmd_ready, rsp_valid}, 4'b0010);
      void'(sb.pop_back());
      synced_m = 1'b0;
      @(negedge CK);
      RST = 1'b0;
      check("tms after abort", TMS_O, 1'b1);
      issue(2'd0, LW'(1), ML'(1), 1'b0, 25);
      wait_rsp("dr after abort", 0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
